// File: rtl/tl_mem_responder_pkg.sv
// Shared opcodes, FSM state encoding and burst-length helper for the
// TileLink-UH memory responder.
package tl_mem_responder_pkg;

    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;

    localparam logic [2:0] D_ACK         = 3'd0;
    localparam logic [2:0] D_ACK_DATA    = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PUT,
        ST_ACK,
        ST_GET
    } tl_state_e;

    // Number of 8-byte beats in a transfer of 2^size bytes. Only meaningful
    // for sizes up to MAX_SIZE; callers force 1 beat for oversized requests.
    function automatic logic [3:0] tl_beats(input logic [3:0] size);
        if (size <= 4'd3) begin
            return 4'd1;
        end
        return 4'd1 << (size - 4'd3);
    endfunction

endpackage

// File: rtl/tl_mem_responder_if.sv
// A/D channel bundle between a TileLink master and the memory responder.
interface tl_mem_responder_if;

    logic        io_a_ready;
    logic        io_a_valid;
    logic [2:0]  io_a_bits_opcode;
    logic [2:0]  io_a_bits_param;
    logic [3:0]  io_a_bits_size;
    logic [1:0]  io_a_bits_source;
    logic [31:0] io_a_bits_address;
    logic [7:0]  io_a_bits_mask;
    logic [63:0] io_a_bits_data;

    logic        io_d_ready;
    logic        io_d_valid;
    logic [2:0]  io_d_bits_opcode;
    logic [1:0]  io_d_bits_param;
    logic [3:0]  io_d_bits_size;
    logic [1:0]  io_d_bits_source;
    logic [1:0]  io_d_bits_sink;
    logic [2:0]  io_d_bits_addr_lo;
    logic [63:0] io_d_bits_data;
    logic        io_d_bits_error;

    modport master (
        input  io_a_ready,
        output io_a_valid, io_a_bits_opcode, io_a_bits_param, io_a_bits_size,
        output io_a_bits_source, io_a_bits_address, io_a_bits_mask, io_a_bits_data,
        output io_d_ready,
        input  io_d_valid, io_d_bits_opcode, io_d_bits_param, io_d_bits_size,
        input  io_d_bits_source, io_d_bits_sink, io_d_bits_addr_lo,
        input  io_d_bits_data, io_d_bits_error
    );

    modport slave (
        output io_a_ready,
        input  io_a_valid, io_a_bits_opcode, io_a_bits_param, io_a_bits_size,
        input  io_a_bits_source, io_a_bits_address, io_a_bits_mask, io_a_bits_data,
        input  io_d_ready,
        output io_d_valid, io_d_bits_opcode, io_d_bits_param, io_d_bits_size,
        output io_d_bits_source, io_d_bits_sink, io_d_bits_addr_lo,
        output io_d_bits_data, io_d_bits_error
    );

endinterface

// File: rtl/tl_mem_responder_mem.sv
// 64-bit wide backing RAM with per-byte write enables and a registered read
// port. Read data appears the cycle after i_rd_en and then holds until the
// next read, which keeps D data stable while the master stalls.
module tl_mem_responder_mem #(
    parameter int WORDS = 8192,
    parameter int IDX_W = 13
) (
    input  logic             clock,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [7:0]       i_wr_be,
    input  logic [63:0]      i_wr_data,
    input  logic             i_rd_en,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [63:0]      o_rd_data
);

    logic [63:0] r_mem [WORDS];

    // Byte-lane writes and registered reads; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_idx];
        end
    end

endmodule

// File: rtl/tl_mem_responder.sv
// TileLink-UH manager: services Get / PutFullData / PutPartialData from a
// byte-enabled RAM, one request outstanding, bursts up to 2^MAX_SIZE bytes.
//
//  state | meaning
//  IDLE  | waiting for first A beat, a_ready=1
//  PUT   | collecting remaining Put beats, a_ready=1
//  ACK   | single AccessAck on D (Put done or unsupported opcode)
//  GET   | streaming AccessAckData beats on D
module tl_mem_responder
    import tl_mem_responder_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int          MEM_BYTES = 65536,
    parameter int          MAX_SIZE  = 6
) (
    input  logic               clock,
    input  logic               reset,
    tl_mem_responder_if.slave  io
);

    localparam int          WORDS   = MEM_BYTES / 8;
    localparam int          IDX_W   = $clog2(WORDS);
    localparam logic [32:0] MEM_END = {1'b0, ADDR_BASE} + 33'(MEM_BYTES);

    tl_state_e        r_state;
    logic [2:0]       r_cnt;
    logic [2:0]       r_last;
    logic [IDX_W-1:0] r_base;
    logic             r_err;
    logic             r_d_valid;
    logic [2:0]       r_d_opcode;
    logic [3:0]       r_d_size;
    logic [1:0]       r_d_source;
    logic [2:0]       r_d_addr_lo;
    logic             r_d_error;

    logic             w_a_ready;
    logic             w_a_fire;
    logic             w_d_fire;
    logic             w_is_put;
    logic             w_is_get;
    logic             w_size_ok;
    logic             w_align_ok;
    logic             w_range_ok;
    logic             w_err;
    logic [31:0]      w_align_mask;
    logic [32:0]      w_end;
    logic [31:0]      w_off;
    logic [3:0]       w_beats;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_cnt_ext;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_rd_en;
    logic [IDX_W-1:0] w_rd_idx;
    logic [63:0]      w_rd_data;
    logic             w_unused;

    // a_ready is a pure state decode so d_ready can never reach it combinationally.
    assign w_a_ready = (r_state == ST_IDLE) || (r_state == ST_PUT);
    assign w_a_fire  = io.io_a_valid && w_a_ready;
    assign w_d_fire  = r_d_valid && io.io_d_ready;

    assign w_is_put     = (io.io_a_bits_opcode == A_PUT_FULL) ||
                          (io.io_a_bits_opcode == A_PUT_PARTIAL);
    assign w_is_get     = (io.io_a_bits_opcode == A_GET);
    assign w_size_ok    = int'(io.io_a_bits_size) <= MAX_SIZE;
    assign w_align_mask = (32'd1 << io.io_a_bits_size) - 32'd1;
    assign w_align_ok   = (io.io_a_bits_address & w_align_mask) == 32'd0;
    assign w_end        = {1'b0, io.io_a_bits_address} + (33'd1 << io.io_a_bits_size);
    assign w_range_ok   = (io.io_a_bits_address >= ADDR_BASE) && (w_end <= MEM_END);
    assign w_err        = !(w_is_put || w_is_get) || !w_size_ok || !w_align_ok || !w_range_ok;
    assign w_beats      = w_size_ok ? tl_beats(io.io_a_bits_size) : 4'd1;

    // Sub-beat requests land in the word at address & ~7; the mask picks lanes.
    assign w_off     = io.io_a_bits_address - ADDR_BASE;
    assign w_idx     = w_off[IDX_W+2:3];
    assign w_cnt_ext = {{(IDX_W-3){1'b0}}, r_cnt};
    assign w_unused  = ^{io.io_a_bits_param, w_off};

    // RAM port steering: writes on accepted Put beats, reads one cycle ahead of each D beat.
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = w_idx;
        w_rd_en  = 1'b0;
        w_rd_idx = w_idx;
        case (r_state)
            ST_IDLE: begin
                w_wr_en = w_a_fire && w_is_put && !w_err;
                w_rd_en = w_a_fire && w_is_get && !w_err;
            end
            ST_PUT: begin
                w_wr_en  = w_a_fire && !r_err;
                w_wr_idx = r_base + w_cnt_ext;
            end
            ST_GET: begin
                w_rd_en  = w_d_fire && (r_cnt != r_last) && !r_d_error;
                w_rd_idx = r_base + w_cnt_ext + {{(IDX_W-1){1'b0}}, 1'b1};
            end
            default: begin
                w_wr_en = 1'b0;
                w_rd_en = 1'b0;
            end
        endcase
    end

    // Request sequencing and registered D-channel header.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_last      <= 3'd0;
            r_base      <= '0;
            r_err       <= 1'b0;
            r_d_valid   <= 1'b0;
            r_d_opcode  <= 3'd0;
            r_d_size    <= 4'd0;
            r_d_source  <= 2'd0;
            r_d_addr_lo <= 3'd0;
            r_d_error   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_a_fire) begin
                        r_base      <= w_idx;
                        r_err       <= w_err;
                        r_last      <= 3'(w_beats - 4'd1);
                        r_d_size    <= io.io_a_bits_size;
                        r_d_source  <= io.io_a_bits_source;
                        r_d_addr_lo <= io.io_a_bits_address[2:0];
                        if (w_is_put && (w_beats != 4'd1)) begin
                            r_state <= ST_PUT;
                            r_cnt   <= 3'd1;
                        end else if (w_is_get) begin
                            r_state    <= ST_GET;
                            r_cnt      <= 3'd0;
                            r_d_valid  <= 1'b1;
                            r_d_opcode <= D_ACK_DATA;
                            r_d_error  <= w_err;
                        end else begin
                            r_state    <= ST_ACK;
                            r_cnt      <= 3'd0;
                            r_d_valid  <= 1'b1;
                            r_d_opcode <= D_ACK;
                            r_d_error  <= w_err;
                        end
                    end
                end
                ST_PUT: begin
                    if (w_a_fire) begin
                        if (r_cnt == r_last) begin
                            r_state    <= ST_ACK;
                            r_cnt      <= 3'd0;
                            r_d_valid  <= 1'b1;
                            r_d_opcode <= D_ACK;
                            r_d_error  <= r_err;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                ST_ACK, ST_GET: begin
                    if (w_d_fire) begin
                        if ((r_state == ST_ACK) || (r_cnt == r_last)) begin
                            r_state     <= ST_IDLE;
                            r_cnt       <= 3'd0;
                            r_d_valid   <= 1'b0;
                            r_d_opcode  <= 3'd0;
                            r_d_size    <= 4'd0;
                            r_d_source  <= 2'd0;
                            r_d_addr_lo <= 3'd0;
                            r_d_error   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    tl_mem_responder_mem #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_mem (
        .clock     (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_be   (io.io_a_bits_mask),
        .i_wr_data (io.io_a_bits_data),
        .i_rd_en   (w_rd_en),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    assign io.io_a_ready        = w_a_ready;
    assign io.io_d_valid        = r_d_valid;
    assign io.io_d_bits_opcode  = r_d_opcode;
    assign io.io_d_bits_param   = 2'd0;
    assign io.io_d_bits_size    = r_d_size;
    assign io.io_d_bits_source  = r_d_source;
    assign io.io_d_bits_sink    = 2'd0;
    assign io.io_d_bits_addr_lo = r_d_addr_lo;
    assign io.io_d_bits_error   = r_d_error;
    assign io.io_d_bits_data    = (r_d_valid && (r_d_opcode == D_ACK_DATA) && !r_d_error)
                                  ? w_rd_data : 64'd0;

endmodule

// File: tb/tb_tl_mem_responder.sv
// Scoreboard bench for tl_mem_responder: stimulus pushes expected D beats,
// a negedge monitor pops and compares on every D fire.
module tb_tl_mem_responder;
    import tl_mem_responder_pkg::*;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  param;
        logic [3:0]  size;
        logic [1:0]  src;
        logic [1:0]  sink;
        logic [2:0]  lo;
        logic [63:0] data;
        logic        err;
    } d_beat_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fire_edge = 0;
    int   accept_edge = 0;
    logic rdy_toggle = 1'b0;
    d_beat_t exp_q [$];

    tl_mem_responder_if bus ();

    tl_mem_responder dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic d_beat_t d_now();
        d_beat_t b;
        b.op    = bus.io_d_bits_opcode;
        b.param = bus.io_d_bits_param;
        b.size  = bus.io_d_bits_size;
        b.src   = bus.io_d_bits_source;
        b.sink  = bus.io_d_bits_sink;
        b.lo    = bus.io_d_bits_addr_lo;
        b.data  = bus.io_d_bits_data;
        b.err   = bus.io_d_bits_error;
        return b;
    endfunction

    task automatic exp_push(input logic [2:0] op, input logic [3:0] sz, input logic [1:0] src,
                            input logic [2:0] lo, input logic [63:0] data, input logic err);
        d_beat_t b;
        b.op = op; b.param = 2'd0; b.size = sz; b.src = src; b.sink = 2'd0;
        b.lo = lo; b.data = data; b.err = err;
        exp_q.push_back(b);
    endtask

    // Present one A beat from posedge+1 and hold it until accepted.
    task automatic a_send(input logic [2:0] op, input logic [3:0] sz, input logic [1:0] src,
                          input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        bus.io_a_valid        = 1'b1;
        bus.io_a_bits_opcode  = op;
        bus.io_a_bits_param   = 3'd0;
        bus.io_a_bits_size    = sz;
        bus.io_a_bits_source  = src;
        bus.io_a_bits_address = addr;
        bus.io_a_bits_mask    = mask;
        bus.io_a_bits_data    = data;
        while (!acc) begin
            @(negedge clock);
            acc = bus.io_a_ready;
            if (acc) accept_edge = cyc + 1;
            @(posedge clock);
            #1;
            n++;
            if (!acc && n > 200) begin
                check("a_accept_timeout", 128'(n), 128'(0));
                acc = 1'b1;
            end
        end
        bus.io_a_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check(name, 128'(exp_q.size()), 128'(0));
            exp_q.delete();
        end
        #1;
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial forever begin
        @(posedge clock);
        #1;
        if (rdy_toggle) bus.io_d_ready = ~bus.io_d_ready;
        else            bus.io_d_ready = 1'b1;
    end

    // Monitor: compare every D fire against the scoreboard, plus handshake rules.
    initial begin
        d_beat_t cur;
        d_beat_t prev_bits;
        d_beat_t e;
        logic    prev_stall;
        prev_stall = 1'b0;
        prev_bits  = '0;
        forever begin
            @(negedge clock);
            if (reset && bus.io_d_valid) begin
                cur = d_now();
                check("a_ready_low_while_d", 128'(bus.io_a_ready), 128'(0));
                if (prev_stall) check("d_stable_stalled", 128'(cur), 128'(prev_bits));
                if (bus.io_d_ready) begin
                    fire_edge = cyc + 1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_d_beat", 128'(cur), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("d_beat", 128'(cur), 128'(e));
                    end
                end
                prev_stall = !bus.io_d_ready;
                prev_bits  = cur;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.io_a_valid        = 1'b0;
        bus.io_a_bits_opcode  = 3'd0;
        bus.io_a_bits_param   = 3'd0;
        bus.io_a_bits_size    = 4'd0;
        bus.io_a_bits_source  = 2'd0;
        bus.io_a_bits_address = 32'd0;
        bus.io_a_bits_mask    = 8'd0;
        bus.io_a_bits_data    = 64'd0;

        repeat (3) @(posedge clock);
        #2;
        check("rst_a_ready", 128'(bus.io_a_ready), 128'(1));
        check("rst_d_valid", 128'(bus.io_d_valid), 128'(0));
        check("rst_d_bits", 128'(d_now()), 128'(0));
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // 1: full-word Put then Get
        exp_push(D_ACK, 4'd3, 2'd1, 3'd0, 64'd0, 1'b0);
        a_send(A_PUT_FULL, 4'd3, 2'd1, 32'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788);
        drain("t1_put_timeout");
        exp_push(D_ACK_DATA, 4'd3, 2'd2, 3'd0, 64'h1122_3344_5566_7788, 1'b0);
        a_send(A_GET, 4'd3, 2'd2, 32'h8000_0010, 8'hFF, 64'd0);
        drain("t1_get_timeout");

        // 2: single-byte PutPartial into lane 3
        exp_push(D_ACK, 4'd0, 2'd3, 3'd3, 64'd0, 1'b0);
        a_send(A_PUT_PARTIAL, 4'd0, 2'd3, 32'h8000_0013, 8'h08, 64'h0000_0000_AB00_0000);
        drain("t2_put_timeout");
        exp_push(D_ACK_DATA, 4'd3, 2'd0, 3'd0, 64'h1122_3344_AB66_7788, 1'b0);
        a_send(A_GET, 4'd3, 2'd0, 32'h8000_0010, 8'hFF, 64'd0);
        drain("t2_get_timeout");

        // 3: 64 B burst write, then read back with d_ready toggling
        exp_push(D_ACK, 4'd6, 2'd1, 3'd0, 64'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            a_send(A_PUT_FULL, 4'd6, 2'd1, 32'h8000_0040, 8'hFF, 64'(i) * 64'h0101_0101_0101_0101);
        end
        drain("t3_put_timeout");
        rdy_toggle = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_push(D_ACK_DATA, 4'd6, 2'd2, 3'd0, 64'(i) * 64'h0101_0101_0101_0101, 1'b0);
        end
        a_send(A_GET, 4'd6, 2'd2, 32'h8000_0040, 8'hFF, 64'd0);
        drain("t3_get_timeout");
        rdy_toggle = 1'b0;
        @(posedge clock);
        #1;

        // 4: error cases and boundaries
        exp_push(D_ACK_DATA, 4'd3, 2'd1, 3'd0, 64'd0, 1'b1);
        a_send(A_GET, 4'd3, 2'd1, 32'h7FFF_FFF8, 8'hFF, 64'd0);
        drain("t4_below_timeout");
        exp_push(D_ACK_DATA, 4'd3, 2'd2, 3'd4, 64'd0, 1'b1);
        a_send(A_GET, 4'd3, 2'd2, 32'h8000_0004, 8'hFF, 64'd0);
        drain("t4_misalign_timeout");
        exp_push(D_ACK, 4'd3, 2'd3, 3'd0, 64'd0, 1'b1);
        a_send(3'd2, 4'd3, 2'd3, 32'h8000_0010, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
        drain("t4_badop_timeout");
        exp_push(D_ACK, 4'd3, 2'd0, 3'd0, 64'd0, 1'b1);
        a_send(A_PUT_FULL, 4'd3, 2'd0, 32'h8001_0000, 8'hFF, 64'hCAFE_CAFE_CAFE_CAFE);
        drain("t4_put_oor_timeout");
        exp_push(D_ACK_DATA, 4'd7, 2'd1, 3'd0, 64'd0, 1'b1);
        a_send(A_GET, 4'd7, 2'd1, 32'h8000_0000, 8'hFF, 64'd0);
        drain("t4_oversize_timeout");
        exp_push(D_ACK, 4'd3, 2'd2, 3'd0, 64'd0, 1'b0);
        a_send(A_PUT_FULL, 4'd3, 2'd2, 32'h8000_FFF8, 8'hFF, 64'h0F0E_0D0C_0B0A_0908);
        drain("t4_lastword_put_timeout");
        exp_push(D_ACK_DATA, 4'd3, 2'd2, 3'd0, 64'h0F0E_0D0C_0B0A_0908, 1'b0);
        a_send(A_GET, 4'd3, 2'd2, 32'h8000_FFF8, 8'hFF, 64'd0);
        drain("t4_lastword_get_timeout");
        exp_push(D_ACK_DATA, 4'd3, 2'd0, 3'd0, 64'h1122_3344_AB66_7788, 1'b0);
        a_send(A_GET, 4'd3, 2'd0, 32'h8000_0010, 8'hFF, 64'd0);
        drain("t4_unchanged_timeout");

        // 5: reset in the middle of a 64 B Get
        for (int i = 0; i < 8; i++) begin
            exp_push(D_ACK_DATA, 4'd6, 2'd3, 3'd0, 64'(i) * 64'h0101_0101_0101_0101, 1'b0);
        end
        a_send(A_GET, 4'd6, 2'd3, 32'h8000_0040, 8'hFF, 64'd0);
        begin
            int n;
            n = 0;
            while (exp_q.size() != 5 && n < 100) begin
                @(posedge clock);
                n++;
            end
            if (exp_q.size() != 5) check("t5_beat_wait_timeout", 128'(exp_q.size()), 128'(5));
        end
        #1;
        reset = 1'b0;
        #1;
        check("t5_rst_d_valid", 128'(bus.io_d_valid), 128'(0));
        check("t5_rst_a_ready", 128'(bus.io_a_ready), 128'(1));
        check("t5_rst_d_bits", 128'(d_now()), 128'(0));
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        exp_push(D_ACK_DATA, 4'd3, 2'd1, 3'd0, 64'h1122_3344_AB66_7788, 1'b0);
        a_send(A_GET, 4'd3, 2'd1, 32'h8000_0010, 8'hFF, 64'd0);
        drain("t5_after_timeout");

        // 6: second Get waiting behind the first
        exp_push(D_ACK_DATA, 4'd3, 2'd0, 3'd0, 64'h1122_3344_AB66_7788, 1'b0);
        a_send(A_GET, 4'd3, 2'd0, 32'h8000_0010, 8'hFF, 64'd0);
        exp_push(D_ACK_DATA, 4'd3, 2'd1, 3'd0, 64'h0101_0101_0101_0101, 1'b0);
        a_send(A_GET, 4'd3, 2'd1, 32'h8000_0048, 8'hFF, 64'd0);
        check("t6_accept_after_fire", 128'(accept_edge), 128'(fire_edge + 1));
        drain("t6_timeout");

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
